coriolis_fpmul_share_arb: RTL
=============================

Name: coriolis_fpmul_share_arb

Overview:
- Time-multiplexes one pipelined FloPoCo FP multiplier (34-bit: 2 exception bits + IEEE single) between NREQ streaming requesters in the coriolis kernels.
- Each requester presents an operand pair with valid/ready and receives its product on a dedicated valid/ready output port.
- The block does round-robin arbitration and tracks requester tags through the multiplier latency.
- It buffers one result per requester and drives the multiplier stall input under back-pressure.

Parameters:
- STREAMW, 34, operand/result width (FloPoCo format incl. 2-bit exception field)
- NREQ, 2, number of requesters (2..8)
- MUL_LAT, 3, multiplier pipeline depth in non-stalled cycles (>=1)
- TAGW, 1, tag width = max(1, clog2(NREQ))

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  operand pair valid, bit i = requester i
- req_ready  out  NREQ  operand pair accepted this cycle
- req_x  in  NREQ*STREAMW  X operands, requester i at [i*STREAMW +: STREAMW]
- req_y  in  NREQ*STREAMW  Y operands, same packing
- res_valid  out  NREQ  result valid per requester
- res_ready  in  NREQ  downstream ready per requester
- res_data  out  NREQ*STREAMW  results, same packing
- mul_x  out  STREAMW  to multiplier X
- mul_y  out  STREAMW  to multiplier Y
- mul_stall  out  1  to multiplier stall (1 = hold all pipeline registers)
- mul_r  in  STREAMW  multiplier result (valid when tag-pipe tail valid)
- busy  out  1  any tag-pipe stage or result buffer occupied

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - Reset clears tag pipe valids, res_valid and res_data to 0 and sets the RR pointer to 0.
  - req_ready=0 and mul_stall=0 during reset.
  - An in-flight operation at reset is discarded; no result is emitted for it.
- Tag pipe:
  - MUL_LAT stages of {v, tag}, advanced only when mul_stall=0. Stage 0 loads {issue, grant_idx}.
  - tail = stage MUL_LAT-1.
  - When tail.v=1, mul_r is the product for requester tail.tag.
- Result buffer per requester i: one entry (res_valid[i], res_data[i]), registered outputs.
  - Cleared when res_valid[i] & res_ready[i].
  - Loaded from mul_r when tail.v & tail.tag==i & ~mul_stall.
  - Load and drain in the same cycle: load wins, and res_valid stays 1.
- Stall: mul_stall = tail.v & res_valid[tail.tag] & ~res_ready[tail.tag]. It is combinational from registers and res_ready.
- Arbitration, when mul_stall=0:
  - grant = first i with req_valid[i]=1, searching cyclically from the RR pointer.
  - req_ready[grant]=1, all other bits 0; issue = that handshake.
  - mul_x/mul_y are muxed from the granted requester's operands.
  - On issue, pointer <= grant+1 mod NREQ. Without an issue, the pointer holds.
  - When mul_stall=1: req_ready=0 and no issue. mul_x/mul_y are don't-care because the multiplier holds.
- Latency:
  - Accept at edge t gives res_valid at edge t+MUL_LAT+1, assuming no stall cycles.
  - Each stall cycle adds one cycle.
- Throughput: one issue per cycle aggregate. Results are delivered in issue order per requester.
- Fairness: a continuously valid requester is granted within NREQ issue cycles.
- A requester may deassert req_valid without being granted; no state is held for it.
- busy = OR(tag v) | OR(res_valid).

Test Plan:
- Single requester 0: X={2'b01,32'h40000000}, Y={2'b01,32'h40400000}, res_ready=1 -> res_valid[0] exactly 4 cycles after accept, res_data[0]={2'b01,32'h40C00000}; busy returns to 0 afterwards.
- Both requesters valid every cycle, 8 pairs each, all res_ready=1 -> grants alternate 0,1,0,1.
  - One issue per cycle.
  - Each requester receives 8 correct products in order; no gaps after fill.
- Requester 1 res_ready=0 while it has a buffered result and a second result reaches the tail -> mul_stall=1 and req_ready=0.
  - Requester 0 traffic also halts.
  - Raising res_ready resumes with no loss or duplication.
- Simultaneous load and drain on requester 0 (res_ready=1, back-to-back results) -> res_valid[0] stays 1 and each value is transferred exactly once.
- Assert rst for 1 cycle with 3 ops in flight -> all res_valid=0 next cycle.
  - No stale results appear later.
  - The next accepted op is granted from requester 0 first.
- NREQ=4, only requesters 1 and 3 valid -> grants alternate 1,3.
  - Requester 2 becomes valid after a grant to 1 -> it is granted next (2 precedes 3 in the cyclic search).

Source files
------------

// File: rtl/coriolis_fpmul_share_arb_if.sv
// Requester-side bus of the shared FP multiplier arbiter: operand pairs in, products out.
// Lane i of every packed vector belongs to requester i.
interface coriolis_fpmul_share_arb_if #(
    parameter int STREAMW = 34,
    parameter int NREQ    = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*STREAMW-1:0] req_x;
    logic [NREQ*STREAMW-1:0] req_y;
    logic [NREQ-1:0]         res_valid;
    logic [NREQ-1:0]         res_ready;
    logic [NREQ*STREAMW-1:0] res_data;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_data
    );
endinterface

// File: rtl/coriolis_fpmul_share_arb.sv
// Round-robin sharing of one pipelined FloPoCo multiplier between NREQ requesters.
// Tags ride alongside the multiplier pipe; one result buffer per requester back-pressures via mul_stall.
module coriolis_fpmul_share_arb #(
    parameter int STREAMW = 34,
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 3,
    parameter int TAGW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    coriolis_fpmul_share_arb_if.slave bus,
    output logic [STREAMW-1:0]        mul_x,
    output logic [STREAMW-1:0]        mul_y,
    output logic                      mul_stall,
    input  logic [STREAMW-1:0]        mul_r,
    output logic                      busy
);

    logic [MUL_LAT-1:0]                tag_v_q, tag_v_d;
    logic [MUL_LAT-1:0][TAGW-1:0]      tag_q, tag_d;
    logic [NREQ-1:0]                   res_valid_q, res_valid_d;
    logic [NREQ-1:0][STREAMW-1:0]      res_data_q, res_data_d;
    logic [TAGW-1:0]                   ptr_q, ptr_d;

    logic                              tail_v;
    logic [TAGW-1:0]                   tail_tag;
    logic                              stall;
    logic                              grant_found;
    logic [TAGW-1:0]                   grant_idx;
    logic                              issue;

    // Stall only when the tail product has nowhere to go this cycle.
    always_comb begin
        tail_v   = tag_v_q[MUL_LAT-1];
        tail_tag = tag_q[MUL_LAT-1];
        stall    = 1'b0;
        if (!rst && tail_v) begin
            stall = res_valid_q[tail_tag] & ~bus.res_ready[tail_tag];
        end else begin
            stall = 1'b0;
        end
    end

    // Cyclic search from the RR pointer; operand mux follows the grant.
    always_comb begin
        grant_found   = 1'b0;
        grant_idx     = ptr_q;
        bus.req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = TAGW'((int'(ptr_q) + k) % NREQ);
            end else begin
                grant_idx   = grant_idx;
            end
        end
        issue = grant_found & ~stall & ~rst;
        if (issue) begin
            bus.req_ready[grant_idx] = 1'b1;
        end else begin
            bus.req_ready = '0;
        end
        mul_x = bus.req_x[int'(grant_idx)*STREAMW +: STREAMW];
        mul_y = bus.req_y[int'(grant_idx)*STREAMW +: STREAMW];
    end

    // Next state: tag pipe shift, result buffer load/drain, pointer advance.
    always_comb begin
        tag_v_d     = tag_v_q;
        tag_d       = tag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (!stall) begin
            tag_v_d[0] = issue;
            tag_d[0]   = grant_idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_v_d[s] = tag_v_q[s-1];
                tag_d[s]   = tag_q[s-1];
            end
        end else begin
            tag_v_d = tag_v_q;
        end
        // A load in the same cycle as a drain overrides the drain.
        for (int i = 0; i < NREQ; i++) begin
            res_valid_d[i] = res_valid_q[i] & ~bus.res_ready[i];
            if (tail_v && !stall && (tail_tag == TAGW'(i))) begin
                res_valid_d[i] = 1'b1;
                res_data_d[i]  = mul_r;
            end else begin
                res_data_d[i]  = res_data_q[i];
            end
        end
        if (issue) begin
            ptr_d = TAGW'((int'(grant_idx) + 1) % NREQ);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers with synchronous reset; in-flight tags are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q     <= '0;
            tag_q       <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            ptr_q       <= '0;
        end else begin
            tag_v_q     <= tag_v_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign mul_stall     = stall;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = (|tag_v_q) | (|res_valid_q);

endmodule
